uart_tx_buf: RTL and testbench

// - Parametrised, buffered UART transmitter. It is the next generation of the bus-side serial TX.
// - Adds a TX FIFO, configurable data width, 1 or 2 stop bits and optional parity.
// - Sits between the CPU bus peripheral register and the tx pin.
// - Lets the CPU queue bytes without polling between frames; frames go out back-to-back.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 59 +++++
 rtl/uart_tx_buf.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_buf.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, bit-period and counter-width helpers.
// Used by the buffered transmitter and intended for the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_PARITY = 3'd3,
        UART_STOP   = 3'd4
    } uart_state_e;

    // Clocks per serial bit for a clock given in MHz.
    function automatic int uart_cycle(input int clk_fre_mhz, input int baud_rate);
        return (clk_fre_mhz * 1_000_000) / baud_rate;
    endfunction

    // Bits needed for a counter running 0..max_val (never less than one bit).
    function automatic int uart_cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Show-ahead synchronous FIFO: dout is the oldest entry whenever empty is low.
// Writes while full and reads while empty are ignored; full/empty come from the count.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q + CW'(do_wr) - CW'(do_rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO-fed framer, start + DATA_BITS LSB-first + optional parity + STOP_BITS.
// Parity bit is compiled in only when UART_TX_PARITY_EN is defined; queued frames go out back-to-back.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int CLK_FRE    = 50,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_p,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CYCLE    = uart_cycle(CLK_FRE, BAUD_RATE);
    localparam int BAUD_MAX = STOP_BITS * CYCLE - 1;
    localparam int BW       = uart_cnt_width(BAUD_MAX);
    localparam int NW       = uart_cnt_width(DATA_BITS - 1);

    localparam logic [BW-1:0] BIT_END  = BW'(CYCLE - 1);
    localparam logic [BW-1:0] STOP_END = BW'(BAUD_MAX);
    localparam logic [NW-1:0] LAST_BIT = NW'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CYCLE < 1) begin : g_bad_cfg
        $error("uart_tx_buf: illegal parameter set");
    end

    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full, fifo_empty, pop;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (tx_valid),
        .rd_en (pop),
        .din   (din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    uart_state_e          state_q, state_d;
    logic [BW-1:0]        baud_cnt_q, baud_cnt_d;
    logic [NW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_p_q, tx_p_d;
    logic                 busy_q, busy_d;
    logic                 pending_q, pending_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // The FSM sees FIFO occupancy one cycle late, giving the fixed two-clock push-to-start latency.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_p_d     = tx_p_q;
        pending_d  = !fifo_empty;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            UART_IDLE: begin
                if (pending_q) begin
                    pop = 1'b1;
                end
            end
            UART_START: begin
                if (baud_cnt_q == BIT_END) begin
                    baud_cnt_d = '0;
                    state_d    = UART_DATA;
                    tx_p_d     = shift_q[0];
                    shift_d    = shift_q >> 1;
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
            UART_DATA: begin
                if (baud_cnt_q == BIT_END) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = UART_PARITY;
                        tx_p_d  = parity_q;
`else
                        state_d = UART_STOP;
                        tx_p_d  = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + NW'(1);
                        tx_p_d    = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            UART_PARITY: begin
                if (baud_cnt_q == BIT_END) begin
                    baud_cnt_d = '0;
                    state_d    = UART_STOP;
                    tx_p_d     = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
`endif
            UART_STOP: begin
                if (baud_cnt_q == STOP_END) begin
                    if (pending_q) begin
                        pop = 1'b1;
                    end else begin
                        state_d = UART_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = UART_IDLE;
                tx_p_d  = 1'b1;
            end
        endcase

        // Frame load is shared by the idle start and the back-to-back restart from STOP.
        if (pop) begin
            state_d    = UART_START;
            tx_p_d     = 1'b0;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = fifo_dout;
`ifdef UART_TX_PARITY_EN
            parity_d   = ^fifo_dout ^ PARITY_ODD[0];
`endif
        end
        busy_d = (state_d != UART_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= UART_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_p_q     <= 1'b1;
            busy_q     <= 1'b0;
            pending_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_p_q     <= tx_p_d;
            busy_q     <= busy_d;
            pending_q  <= pending_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx_p     = tx_p_q;
    assign busy     = busy_q;
    assign tx_ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf at CYCLE=10: an 8N1 instance and a 7-data/2-stop instance.
// Expected frames are written out by hand in transmission order; parity insertion follows the build.
module tb_uart_tx_buf;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NB = PAR_EN ? 11 : 10;
    localparam int FL = NB * 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din;
    logic       tx_valid, tx_ready, tx_p, busy;
    logic [4:0] fifo_count;
    logic [6:0] f_din;
    logic       f_valid, f_ready, f_tx_p, f_busy;
    logic [4:0] f_count;

    always #5 clk = ~clk;

    uart_tx_buf #(.CLK_FRE(1), .BAUD_RATE(100000)) u_dut (
        .clk(clk), .rst(rst), .din(din), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_p(tx_p), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx_buf #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(7), .STOP_BITS(2)) u_fmt (
        .clk(clk), .rst(rst), .din(f_din), .tx_valid(f_valid), .tx_ready(f_ready),
        .tx_p(f_tx_p), .busy(f_busy), .fifo_count(f_count)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         sel;
        logic [7:0] d;
        logic [9:0] pat;
        int         ns;
        bit         par;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] obs(input bit sel);
        return sel ? {f_tx_p, f_busy, f_count} : {tx_p, busy, fifo_count};
    endfunction

    // Insert the parity bit ahead of the ns stop bits when parity is built in.
    function automatic logic [63:0] with_par(input logic [9:0] pat, input int ns, input bit par);
        logic [63:0] p, hi, lo;
        p  = 64'(pat);
        hi = p >> ns;
        lo = p & ((64'd1 << ns) - 64'd1);
        return PAR_EN ? ((hi << (ns + 1)) | (64'(par) << ns) | lo) : p;
    endfunction

    function automatic logic [63:0] model_frame(input logic [7:0] d);
        logic [63:0] f;
        f = 64'd0;
        for (int i = 0; i < 8; i++) f = (f << 1) | 64'(d[i]);
        if (PAR_EN) f = (f << 1) | 64'(^d);
        return (f << 1) | 64'd1;
    endfunction

    task automatic push(input bit sel, input logic [7:0] d);
        if (sel) begin f_din = d[6:0]; f_valid = 1'b1; end
        else begin din = d; tx_valid = 1'b1; end
        @(negedge clk);
        tx_valid = 1'b0;
        f_valid  = 1'b0;
    endtask

    // Entered on the first negedge of a start bit; samples mid-bit until busy falls.
    task automatic measure(input bit sel, output logic [63:0] bits, output int cyc,
                           output logic [4:0] c0, output logic [4:0] c1, output logic [4:0] c2);
        bits = 64'd0; cyc = 0; c0 = '0; c1 = '0; c2 = '0;
        while ((sel ? f_busy : busy) && cyc < 1000) begin
            if (cyc % 10 == 5) bits = (bits << 1) | 64'(sel ? f_tx_p : tx_p);
            if (cyc == 0)      c0 = sel ? f_count : fifo_count;
            if (cyc == FL)     c1 = fifo_count;
            if (cyc == 2 * FL) c2 = fifo_count;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_single(input bit sel, input logic [7:0] d, input logic [9:0] pat,
                              input int ns, input bit par, input string tag);
        logic [63:0] bits;
        int          cyc;
        logic [4:0]  c0, c1, c2;
        push(sel, d);
        check({tag, "_lat1"}, 64'(obs(sel)), 64'({1'b1, 1'b0, 5'd1}));
        @(negedge clk);
        check({tag, "_lat2"}, 64'(obs(sel)), 64'({1'b1, 1'b0, 5'd1}));
        @(negedge clk);
        check({tag, "_start"}, 64'(obs(sel)), 64'({1'b0, 1'b1, 5'd0}));
        measure(sel, bits, cyc, c0, c1, c2);
        check({tag, "_busy_clk"}, 64'(cyc), 64'(FL));
        check({tag, "_bits"}, bits, with_par(pat, ns, par));
        check({tag, "_idle"}, 64'(obs(sel)), 64'({1'b1, 1'b0, 5'd0}));
    endtask

    task automatic rx_frame(output logic [63:0] bits);
        int w;
        w = 0;
        bits = 64'd0;
        while (tx_p !== 1'b0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("rx_start_seen", 64'(w < 500), 64'd1);
        repeat (5) @(negedge clk);
        for (int j = 0; j < NB; j++) begin
            bits = (bits << 1) | 64'(tx_p);
            if (j < NB - 1) repeat (10) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bits, exp;
        int          cyc, w, lows;
        logic [4:0]  c0, c1, c2;

        din = '0; tx_valid = 1'b0; f_din = '0; f_valid = 1'b0;
        vecs[0] = '{1'b0, 8'hA5, 10'b0101001011, 1, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 10'b0000000001, 1, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 10'b0111111111, 1, 1'b0};
        vecs[3] = '{1'b0, 8'h07, 10'b0111000001, 1, 1'b1};
        vecs[4] = '{1'b0, 8'h80, 10'b0000000011, 1, 1'b1};
        vecs[5] = '{1'b1, 8'h55, 10'b0101010111, 2, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_main", 64'({obs(0), tx_ready}), 64'({1'b1, 1'b0, 5'd0, 1'b1}));
        check("rst_fmt",  64'({obs(1), f_ready}),  64'({1'b1, 1'b0, 5'd0, 1'b1}));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_single(vecs[i].sel, vecs[i].d, vecs[i].pat, vecs[i].ns, vecs[i].par,
                       $sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
        end

        // Back-to-back frames from pushes on consecutive cycles.
        din = 8'h01; tx_valid = 1'b1;
        @(negedge clk);
        check("b2b_cnt_a", 64'(fifo_count), 64'd1);
        din = 8'h02;
        @(negedge clk);
        check("b2b_cnt_b", 64'(fifo_count), 64'd2);
        din = 8'h03;
        @(negedge clk);
        tx_valid = 1'b0;
        check("b2b_start", 64'(obs(0)), 64'({1'b0, 1'b1, 5'd2}));
        measure(1'b0, bits, cyc, c0, c1, c2);
        exp = (with_par(10'b0100000001, 1, 1'b1) << (2 * NB)) |
              (with_par(10'b0010000001, 1, 1'b1) << NB) |
               with_par(10'b0110000001, 1, 1'b0);
        check("b2b_busy_clk", 64'(cyc), 64'(3 * FL));
        check("b2b_bits", bits, exp);
        check("b2b_counts", 64'({c0, c1, c2}), 64'({5'd2, 5'd1, 5'd0}));
        repeat (3) @(negedge clk);

        // Overflow: an all-ones frame keeps the serial side busy while 17 words arrive.
        push(1'b0, 8'hFF);
        repeat (2) @(negedge clk);
        check("ovf_hold_start", 64'(obs(0)), 64'({1'b0, 1'b1, 5'd0}));
        for (int i = 0; i < 17; i++) begin
            check($sformatf("ovf_rdy_cnt%0d", i), 64'({tx_ready, fifo_count}),
                  64'({(i < 16), 5'(i)}));
            din = 8'(i); tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("ovf_full", 64'({tx_ready, fifo_count}), 64'({1'b0, 5'd16}));
        repeat (FL - 22) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            rx_frame(bits);
            check($sformatf("ovf_frame%0d", k), bits, model_frame(8'(k)));
        end
        w = 0;
        while (busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ovf_drain", 64'(obs(0)), 64'({1'b1, 1'b0, 5'd0}));
        lows = 0;
        repeat (2 * FL) begin
            @(negedge clk);
            if (tx_p == 1'b0 || busy) lows++;
        end
        check("ovf_no_extra", 64'(lows), 64'd0);

        // Reset during the third data bit with two words still queued.
        din = 8'h11; tx_valid = 1'b1;
        @(negedge clk);
        din = 8'h22;
        @(negedge clk);
        din = 8'h33;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (35) @(negedge clk);
        check("rstmid_pre", 64'(obs(0)), 64'({1'b0, 1'b1, 5'd2}));
        rst = 1'b1;
        #1;
        check("rstmid_now", 64'({obs(0), tx_ready}), 64'({1'b1, 1'b0, 5'd0, 1'b1}));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_single(1'b0, 8'h3C, 10'b0001111001, 1, 1'b0, "rstmid_3c");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
